// File: rtl/posit_decoder_param.sv
// Iterative posit<N,ES> decoder: scans the regime one bit per clock, then extracts exponent and fraction.
// Define POSIT_DEC_SCALE_EN to add the registered combined scale output (k*2^ES + exponent).
module posit_decoder_param #(
    parameter int N  = 32,
    parameter int ES = 2,
    localparam int KW = $clog2(N-1) + 1,
    localparam int FW = N - 3 - ES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         posit_num,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 sign,
    output logic                 zero,
    output logic                 nar,
    output logic signed [KW-1:0] k,
    output logic [ES-1:0]        exp_value,
    output logic [FW-1:0]        mantissa
`ifdef POSIT_DEC_SCALE_EN
    ,
    output logic signed [KW+ES-1:0] scale
`endif
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N-1);

    typedef enum logic [1:0] {IDLE, LOAD, REGIME, EXTRACT} state_t;

    state_t               state;
    state_t               state_n;
    logic [N-1:0]         word;
    logic [N-2:0]         sh;
    logic [N-2:0]         body;
    logic [N-2:0]         sh_t;
    logic                 run_bit;
    logic                 sign_r;
    logic                 special;
    logic                 run_cont;
    logic [CW-1:0]        cnt;
    logic [ES-1:0]        exp_n;
    logic [FW-1:0]        mant_n;
    logic signed [KW-1:0] k_n;
    logic [1:0]           unused_lsb;

    always_comb begin
        // Zero and NaR both have an all-zero body; the MSB tells them apart.
        special  = ~|word[N-2:0];
        body     = word[N-1] ? (~word[N-2:0] + (N-1)'(1)) : word[N-2:0];
        run_cont = (sh[N-2] == run_bit) && (cnt < CNT_MAX);
        sh_t     = (cnt < CNT_MAX) ? (sh << 1) : sh;
        exp_n    = sh_t[N-2 -: ES];
        // At least two shifts have happened by now, so the two LSBs are always zero.
        mant_n     = sh_t[N-2-ES -: FW];
        unused_lsb = sh_t[1:0];
        k_n = run_bit ? (KW'(cnt) - KW'(1)) : (KW'(0) - KW'(cnt));
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    state_n = special ? IDLE : REGIME;
            REGIME:  if (!run_cont) state_n = EXTRACT;
            EXTRACT: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            word      <= '0;
            sh        <= '0;
            run_bit   <= 1'b0;
            sign_r    <= 1'b0;
            cnt       <= '0;
            done      <= 1'b0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            nar       <= 1'b0;
            k         <= '0;
            exp_value <= '0;
            mantissa  <= '0;
`ifdef POSIT_DEC_SCALE_EN
            scale     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) word <= posit_num;
                end
                LOAD: begin
                    if (special) begin
                        done      <= 1'b1;
                        sign      <= 1'b0;
                        zero      <= ~word[N-1];
                        nar       <= word[N-1];
                        k         <= '0;
                        exp_value <= '0;
                        mantissa  <= '0;
`ifdef POSIT_DEC_SCALE_EN
                        scale     <= '0;
`endif
                    end else begin
                        sign_r  <= word[N-1];
                        sh      <= body;
                        run_bit <= body[N-2];
                        cnt     <= '0;
                    end
                end
                REGIME: begin
                    if (run_cont) begin
                        cnt <= cnt + CW'(1);
                        sh  <= sh << 1;
                    end
                end
                EXTRACT: begin
                    done      <= 1'b1;
                    sign      <= sign_r;
                    zero      <= 1'b0;
                    nar       <= 1'b0;
                    k         <= k_n;
                    exp_value <= exp_n;
                    mantissa  <= mant_n;
`ifdef POSIT_DEC_SCALE_EN
                    // exp_n is non-negative and below 2^ES, so concatenation equals k*2^ES + exp.
                    scale     <= {k_n, exp_n};
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_decoder_param.sv
// Self-checking bench for posit_decoder_param: vector table and random words through a scoreboard, plus
// hand-written sequences for busy-start, mid-decode reset and an N=16/ES=1 instance.
module tb_posit_decoder_param;

    typedef struct {
        logic [31:0]        p;
        logic               s;
        logic               z;
        logic               n;
        logic signed [5:0]  k;
        logic [1:0]         e;
        logic [26:0]        m;
        int                 lat;
    } vec_t;

    logic               clk;
    logic               rst;
    logic [31:0]        posit_num;
    logic               start;
    logic               busy, done, sign, zero, nar;
    logic signed [5:0]  k;
    logic [1:0]         exp_value;
    logic [26:0]        mantissa;

    logic [15:0]        p16;
    logic               start16;
    logic               busy16, done16, sign16, zero16, nar16;
    logic signed [4:0]  k16;
    logic [0:0]         e16;
    logic [11:0]        m16;
`ifdef POSIT_DEC_SCALE_EN
    logic signed [7:0]  scale;
    logic signed [5:0]  scale16;
`endif

    int checks = 0;
    int errors = 0;
    vec_t sb[$];
    vec_t tbl[12];

    posit_decoder_param #(.N(32), .ES(2)) dut (
        .clk(clk), .rst(rst), .posit_num(posit_num), .start(start),
        .busy(busy), .done(done), .sign(sign), .zero(zero), .nar(nar),
        .k(k), .exp_value(exp_value), .mantissa(mantissa)
`ifdef POSIT_DEC_SCALE_EN
        , .scale(scale)
`endif
    );

    posit_decoder_param #(.N(16), .ES(1)) dut16 (
        .clk(clk), .rst(rst), .posit_num(p16), .start(start16),
        .busy(busy16), .done(done16), .sign(sign16), .zero(zero16), .nar(nar16),
        .k(k16), .exp_value(e16), .mantissa(m16)
`ifdef POSIT_DEC_SCALE_EN
        , .scale(scale16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] p, input bit s, input bit z, input bit n,
                                input int kv, input int e, input logic [26:0] m, input int lat);
        vec_t r;
        r.p = p; r.s = s; r.z = z; r.n = n;
        r.k = 6'(kv); r.e = 2'(e); r.m = m; r.lat = lat;
        return r;
    endfunction

    // Bit-walking reference: count the regime run directly on the word.
    function automatic vec_t model(input logic [31:0] p);
        vec_t r;
        logic [31:0] v;
        logic rb;
        int i, m;
        r = mk(p, 0, 0, 0, 0, 0, '0, 1);
        if (p == 32'h0) begin r.z = 1'b1; return r; end
        if (p == 32'h8000_0000) begin r.n = 1'b1; return r; end
        r.s = p[31];
        v = p[31] ? -p : p;
        rb = v[30];
        i = 30;
        m = 0;
        while (i >= 0) begin
            if (v[i] != rb) break;
            m++;
            i--;
        end
        r.k = rb ? 6'(m - 1) : 6'(-m);
        i--;
        for (int j = 0; j < 2; j++) begin
            r.e = {r.e[0], (i >= 0) ? v[i] : 1'b0};
            i--;
        end
        for (int j = 0; j < 27; j++) begin
            r.m = {r.m[25:0], (i >= 0) ? v[i] : 1'b0};
            i--;
        end
        r.lat = m + 3;
        return r;
    endfunction

    // Called at a negedge; returns just after the accepting edge (edge 0).
    task automatic drive(input logic [31:0] p, input vec_t e);
        posit_num = p;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_check(input int pre_edges);
        vec_t e;
        int edges;
        bit got;
        edges = pre_edges;
        got = 1'b0;
        while (edges < 200 && !got) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout p=%h: no done within %0d edges", e.p, edges);
            return;
        end
        chk($sformatf("latency p=%h", e.p), edges, e.lat);
        chk($sformatf("sign p=%h", e.p), sign, e.s);
        chk($sformatf("zero p=%h", e.p), zero, e.z);
        chk($sformatf("nar p=%h", e.p), nar, e.n);
        chk($sformatf("k p=%h", e.p), longint'(k), longint'(e.k));
        chk($sformatf("exp p=%h", e.p), exp_value, e.e);
        chk($sformatf("mant p=%h", e.p), mantissa, e.m);
`ifdef POSIT_DEC_SCALE_EN
        chk($sformatf("scale p=%h", e.p), longint'(scale), longint'(e.k) * 4 + longint'(e.e));
`endif
    endtask

    task automatic run16(input logic [15:0] p, input int kx, input int ex, input int mx, input int lat);
        int edges;
        bit got;
        p16 = p;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        edges = 0;
        got = 1'b0;
        while (edges < 100 && !got) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done16) got = 1'b1;
        end
        chk($sformatf("n16 latency p=%h", p), edges, lat);
        chk($sformatf("n16 k p=%h", p), longint'(k16), kx);
        chk($sformatf("n16 exp p=%h", p), e16, ex);
        chk($sformatf("n16 mant p=%h", p), m16, mx);
`ifdef POSIT_DEC_SCALE_EN
        chk($sformatf("n16 scale p=%h", p), longint'(scale16), kx * 2 + ex);
`endif
    endtask

    initial begin
        int saw_done;
        logic [31:0] r;
        vec_t dummy;

        rst = 1'b0; start = 1'b0; posit_num = '0;
        start16 = 1'b0; p16 = '0;

        tbl[0]  = mk(32'h0DCC_CCCC, 0, 0, 0, -3, 2, {25'b1110011001100110011001100, 2'b00}, 6);
        tbl[1]  = mk(32'hF233_3334, 1, 0, 0, -3, 2, {25'b1110011001100110011001100, 2'b00}, 6);
        tbl[2]  = mk(32'h0000_0000, 0, 1, 0, 0, 0, '0, 1);
        tbl[3]  = mk(32'h8000_0000, 0, 0, 1, 0, 0, '0, 1);
        tbl[4]  = mk(32'h7FFF_FFFF, 0, 0, 0, 30, 0, '0, 34);
        tbl[5]  = mk(32'h0000_0001, 0, 0, 0, -30, 0, '0, 33);
        tbl[6]  = mk(32'h4000_0000, 0, 0, 0, 0, 0, '0, 4);
        tbl[7]  = mk(32'h5000_0000, 0, 0, 0, 0, 2, '0, 4);
        tbl[8]  = mk(32'hC000_0000, 1, 0, 0, 0, 0, '0, 4);
        tbl[9]  = mk(32'h0000_0003, 0, 0, 0, -29, 2, '0, 32);
        tbl[10] = mk(32'h7FFF_FFFE, 0, 0, 0, 29, 0, '0, 33);
        tbl[11] = mk(32'h6D00_0000, 0, 0, 0, 1, 3, 27'h200_0000, 5);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sign", sign, 0);
        chk("reset zero", zero, 0);
        chk("reset nar", nar, 0);
        chk("reset k", longint'(k), 0);
        chk("reset exp", exp_value, 0);
        chk("reset mant", mantissa, 0);
        chk("reset busy16", busy16, 0);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back: each new start is driven in the cycle done is high.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].p, tbl[i]);
            wait_check(0);
        end

        for (int i = 0; i < 10; i++) begin
            r = $urandom;
            drive(r, model(r));
            wait_check(0);
        end

        // Start pulsed while busy, with a changed word, must be ignored.
        drive(32'h0DCC_CCCC, tbl[0]);
        @(negedge clk);
        posit_num = 32'h7FFF_FFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_check(1);
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done++;
        end
        chk("ignored start no activity", saw_done, 0);

        // Reset during REGIME aborts the decode.
        drive(32'h0000_0001, tbl[5]);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset sign", sign, 0);
        chk("midreset k", longint'(k), 0);
        chk("midreset exp", exp_value, 0);
        chk("midreset mant", mantissa, 0);
        rst = 1'b1;
        dummy = sb.pop_front();
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("midreset no done", saw_done, 0);
        drive(32'h0DCC_CCCC, tbl[0]);
        wait_check(0);

        run16(16'h4000, 0, 0, 0, 4);
        @(negedge clk);
        run16(16'h5A00, 0, 1, 12'hA00, 4);
        @(negedge clk);
        run16(16'h7FFF, 14, 0, 0, 18);
        @(negedge clk);
        run16(16'h0001, -14, 0, 0, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
